mdu_sched: RTL and testbench

//  Sequencer for the multiply/divide unit (MDU) in the 5-stage MIPS pipeline.

---
 rtl/mdu_sched.sv | 139 +++++++++++++
 tb/tb_mdu_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_sched
//  Description : MIPS multiply/divide unit sequencer. Launches mult/div ops
//                from E, holds a fixed-latency busy window, commits HI/LO.
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_sched #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  E_mdOp,
    input  logic        E_mdValid,
    input  logic [31:0] E_rsVal,
    input  logic [31:0] E_rtVal,
    input  logic        D_isMd,
    output logic        MD_start,
    output logic        MD_busy,
    output logic        MD_STALL,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] c_opMult  = 3'd1;
    localparam logic [2:0] c_opMultu = 3'd2;
    localparam logic [2:0] c_opDiv   = 3'd3;
    localparam logic [2:0] c_opDivu  = 3'd4;
    localparam logic [2:0] c_opMthi  = 3'd5;
    localparam logic [2:0] c_opMtlo  = 3'd6;

    localparam logic [3:0] c_multCyc = 4'(MULT_CYC);
    localparam logic [3:0] c_divCyc  = 4'(DIV_CYC);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pendHi;
    logic [31:0] r_pendLo;

    logic        w_isArith;
    logic        w_isMult;
    logic [63:0] w_prodS;
    logic [63:0] w_prodU;
    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [31:0] w_qMag;
    logic [31:0] w_rMag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_divZero;
    logic [31:0] w_resHi;
    logic [31:0] w_resLo;
    logic [3:0]  w_lat;

    assign w_isArith = (E_mdOp == c_opMult) || (E_mdOp == c_opMultu) ||
                       (E_mdOp == c_opDiv)  || (E_mdOp == c_opDivu);
    assign w_isMult  = (E_mdOp == c_opMult) || (E_mdOp == c_opMultu);

    assign MD_start = E_mdValid && w_isArith && (r_state == S_IDLE);
    assign MD_busy  = (r_state == S_BUSY);
    assign MD_STALL = D_isMd && (MD_start || MD_busy);

    // Sign-extending to 64 bits makes an unsigned multiply yield the signed product.
    assign w_prodS = {{32{E_rsVal[31]}}, E_rsVal} * {{32{E_rtVal[31]}}, E_rtVal};
    assign w_prodU = {32'b0, E_rsVal} * {32'b0, E_rtVal};

    // Signed divide done on magnitudes; this also gives 0x80000000/-1 = 0x80000000 rem 0.
    assign w_negA    = (E_mdOp == c_opDiv) && E_rsVal[31];
    assign w_negB    = (E_mdOp == c_opDiv) && E_rtVal[31];
    assign w_absA    = w_negA ? (~E_rsVal + 32'd1) : E_rsVal;
    assign w_absB    = w_negB ? (~E_rtVal + 32'd1) : E_rtVal;
    assign w_divZero = (E_rtVal == 32'd0);
    assign w_qMag    = w_divZero ? 32'd0 : (w_absA / w_absB);
    assign w_rMag    = w_divZero ? 32'd0 : (w_absA % w_absB);
    assign w_quot    = (w_negA ^ w_negB) ? (~w_qMag + 32'd1) : w_qMag;
    assign w_rem     = w_negA ? (~w_rMag + 32'd1) : w_rMag;

    assign w_lat = w_isMult ? c_multCyc : c_divCyc;

    always_comb begin
        w_resHi = HI;
        w_resLo = LO;
        case (E_mdOp)
            c_opMult:  {w_resHi, w_resLo} = w_prodS;
            c_opMultu: {w_resHi, w_resLo} = w_prodU;
            c_opDiv, c_opDivu: begin
                if (!w_divZero) begin
                    w_resHi = w_rem;
                    w_resLo = w_quot;
                end
            end
            default: begin
                w_resHi = HI;
                w_resLo = LO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_pendHi <= 32'd0;
            r_pendLo <= 32'd0;
            HI       <= 32'd0;
            LO       <= 32'd0;
        end else if (r_state == S_IDLE) begin
            if (MD_start) begin
                r_pendHi <= w_resHi;
                r_pendLo <= w_resLo;
                r_cnt    <= w_lat;
                r_state  <= S_BUSY;
            end else if (E_mdValid && (E_mdOp == c_opMthi)) begin
                HI <= E_rsVal;
            end else if (E_mdValid && (E_mdOp == c_opMtlo)) begin
                LO <= E_rsVal;
            end
        end else begin
            if (r_cnt == 4'd1) begin
                HI      <= r_pendHi;
                LO      <= r_pendLo;
                r_cnt   <= 4'd0;
                r_state <= S_IDLE;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_sched
//  Description : Randomised scoreboard bench for mdu_sched with a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_sched;

    localparam int c_mult = 5;
    localparam int c_div  = 10;

    logic        clk;
    logic        reset_n;
    logic [2:0]  E_mdOp;
    logic        E_mdValid;
    logic [31:0] E_rsVal;
    logic [31:0] E_rtVal;
    logic        D_isMd;
    logic        MD_start;
    logic        MD_busy;
    logic        MD_STALL;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu_sched #(.MULT_CYC(c_mult), .DIV_CYC(c_div)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .E_mdOp    (E_mdOp),
        .E_mdValid (E_mdValid),
        .E_rsVal   (E_rsVal),
        .E_rtVal   (E_rtVal),
        .D_isMd    (D_isMd),
        .MD_start  (MD_start),
        .MD_busy   (MD_busy),
        .MD_STALL  (MD_STALL),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          nCmp = 0;
    int          nErr = 0;

    int          refLeft = 0;
    logic [31:0] refHi = 32'd0;
    logic [31:0] refLo = 32'd0;
    logic [63:0] pendRef = 64'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result of an MDU op, taken straight from the ISA rules.
    function automatic logic [63:0] refCalc(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] curHi,
                                            input logic [31:0] curLo);
        int              sa, sb, q, r;
        longint          ps;
        longint unsigned pu;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin
                ps = longint'(sa) * longint'(sb);
                return ps;
            end
            3'd2: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                return pu;
            end
            3'd3: begin
                if (b == 32'd0) return {curHi, curLo};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            3'd4: begin
                if (b == 32'd0) return {curHi, curLo};
                return {a % b, a / b};
            end
            default: return {curHi, curLo};
        endcase
    endfunction

    task automatic step(input logic [2:0] op, input logic v, input logic [31:0] rs,
                        input logic [31:0] rt, input logic d);
        logic expStart;
        @(posedge clk);
        #1;
        E_mdOp    = op;
        E_mdValid = v;
        E_rsVal   = rs;
        E_rtVal   = rt;
        D_isMd    = d;
        @(negedge clk);
        expStart = v && (op >= 3'd1) && (op <= 3'd4) && (refLeft == 0);
        chk("start", {31'd0, MD_start}, {31'd0, expStart});
        chk("stall", {31'd0, MD_STALL}, {31'd0, d && (expStart || refLeft > 0)});
        chk("busy", {31'd0, MD_busy}, {31'd0, refLeft > 0});
        if (refLeft == 0) begin
            chk("arch_hi", HI, refHi);
            chk("arch_lo", LO, refLo);
        end
        if (refLeft > 0) begin
            refLeft--;
            if (refLeft == 0) {refHi, refLo} = pendRef;
        end else if (expStart) begin
            pendRef = refCalc(op, rs, rt, refHi, refLo);
            refLeft = (op <= 3'd2) ? c_mult : c_div;
            sbq.push_back('{pendRef[63:32], pendRef[31:0], refLeft});
        end else if (v && op == 3'd5) begin
            refHi = rs;
        end else if (v && op == 3'd6) begin
            refLo = rs;
        end
    endtask

    task automatic idle(input int n, input logic d);
        repeat (n) step(3'd0, 1'b0, 32'd0, 32'd0, d);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every fall of MD_busy is a commit and retires one scoreboard entry.
    int   busyRun  = 0;
    logic prevBusy = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (!reset_n) begin
            busyRun  = 0;
            prevBusy = 1'b0;
        end else begin
            if (MD_busy) begin
                busyRun++;
            end else if (prevBusy) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_commit", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_latency", 32'(busyRun), 32'(e.lat));
                    chk("sb_hi", HI, e.hi);
                    chk("sb_lo", LO, e.lo);
                end
                busyRun = 0;
            end
            prevBusy = MD_busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        E_mdOp    = 3'd0;
        E_mdValid = 1'b0;
        E_rsVal   = 32'd0;
        E_rtVal   = 32'd0;
        D_isMd    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, MD_busy}, 32'd0);
        chk("rst_start", {31'd0, MD_start}, 32'd0);
        chk("rst_stall", {31'd0, MD_STALL}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        step(3'd5, 1'b1, 32'h0000_1234, 32'd0, 1'b0);
        idle(1, 1'b0);
        chk("ex_mthi", HI, 32'h0000_1234);

        step(3'd1, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b1);
        idle(2, 1'b1);
        step(3'd1, 1'b1, 32'd7, 32'd7, 1'b1);
        step(3'd5, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b1);
        idle(1, 1'b1);
        idle(1, 1'b1);
        chk("ex_mult_hi", HI, 32'hFFFF_FFFF);
        chk("ex_mult_lo", LO, 32'hFFFF_FFFA);

        step(3'd2, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(6, 1'b0);
        chk("ex_multu_hi", HI, 32'h0000_0002);
        chk("ex_multu_lo", LO, 32'hFFFF_FFFA);

        step(3'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(11, 1'b0);
        chk("ex_div_hi", HI, 32'hFFFF_FFFF);
        chk("ex_div_lo", LO, 32'hFFFF_FFFD);

        step(3'd4, 1'b1, 32'd5, 32'd0, 1'b0);
        idle(11, 1'b0);
        chk("ex_div0_hi", HI, 32'hFFFF_FFFF);
        chk("ex_div0_lo", LO, 32'hFFFF_FFFD);

        step(3'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(11, 1'b0);
        chk("ex_ovf_hi", HI, 32'd0);
        chk("ex_ovf_lo", LO, 32'h8000_0000);

        // Reset during the third busy cycle of a divide.
        step(3'd5, 1'b1, 32'h0000_ABCD, 32'd0, 1'b0);
        step(3'd3, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(2, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, MD_busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        sbq.delete();
        refLeft = 0;
        refHi   = 32'd0;
        refLo   = 32'd0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(15, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                 randOperand(), randOperand(), 1'($urandom_range(0, 1)));
        end
        idle(20, 1'b0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
